// File: rtl/ula8_sequenciador_pkg.sv
// Shared definitions for the 8-bit sequencer over the 4-bit ULA:
// operation codes, ULA X-code constants and FSM state encoding.
package ula8_sequenciador_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_SLT = 2'b10,
        OP_BEQ = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LO   = 3'd1,
        S_HI   = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // ULA op code packed as {x0, x1, x2}
    localparam logic [2:0] XC_ADD = 3'b000;
    localparam logic [2:0] XC_SUB = 3'b100;
    localparam logic [2:0] XC_CMP = 3'b111;

    function automatic logic [2:0] xcode(input op_t op);
        case (op)
            OP_ADD:  return XC_ADD;
            OP_SUB:  return XC_SUB;
            default: return XC_CMP;
        endcase
    endfunction

endpackage

// File: rtl/ula8_sequenciador.sv
// Initiator for the external combinational 4-bit ULA: runs 8-bit ADD/SUB/SLT/BEQ
// as a low-nibble pass, a high-nibble pass and, when a carry/borrow crosses the
// nibble boundary, a fix-up pass that adds/subtracts 1 on the high nibble.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; ULA inputs held at 0
// LO     | low nibbles on the ULA; capture low result, carry, eq/lt
// HI     | high nibbles on the ULA; capture high result, carry, eq/lt
// FIX    | ADD/SUB only: propagate low-nibble carry/borrow into high nibble
// DONE   | done pulse; result and flags valid and held
module ula8_sequenciador
    import ula8_sequenciador_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       flag_zero,
    output logic       flag_carry,
    output logic [3:0] ula_a,
    output logic [3:0] ula_b,
    output logic       ula_x0,
    output logic       ula_x1,
    output logic       ula_x2,
    input  logic [3:0] ula_f0,
    input  logic [3:0] ula_igual,
    input  logic [3:0] ula_menor
);

    state_t     st, nxt;
    op_t        op_q;
    logic [7:0] a_q, b_q;
    logic [3:0] r_lo, r_hi;
    logic       c, hc, lo_eq, lo_lt;
    logic [2:0] xc;
    logic       carry_now;
    logic       is_arith;
    logic       less, equal, fix_c;
    logic [7:0] arith_res;

    assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);

    // The ULA exposes no carry: ADD wrapped if the sum is below an addend,
    // SUB borrowed if the minuend is below the subtrahend.
    assign carry_now = (op_q == OP_ADD) ? (ula_f0 < ula_a) : (ula_a < ula_b);
    assign less      = ula_menor[0] | (ula_igual[0] & lo_lt);
    assign equal     = ula_igual[0] & lo_eq;
    assign fix_c     = (op_q == OP_ADD) ? (ula_f0 == 4'h0) : (r_hi == 4'h0);
    assign arith_res = {ula_f0, r_lo};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= S_IDLE;
        else        st <= nxt;
    end

    // Next state and ULA drive
    always_comb begin
        nxt    = st;
        busy   = (st != S_IDLE);
        done   = 1'b0;
        ula_a  = 4'h0;
        ula_b  = 4'h0;
        xc     = 3'b000;
        case (st)
            S_IDLE: if (start) nxt = S_LO;
            S_LO: begin
                ula_a = a_q[3:0];
                ula_b = b_q[3:0];
                xc    = xcode(op_q);
                nxt   = S_HI;
            end
            S_HI: begin
                ula_a = a_q[7:4];
                ula_b = b_q[7:4];
                xc    = xcode(op_q);
                nxt   = (is_arith && c) ? S_FIX : S_DONE;
            end
            S_FIX: begin
                ula_a = r_hi;
                ula_b = 4'h1;
                xc    = xcode(op_q);
                nxt   = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                nxt  = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    assign ula_x0 = xc[2];
    assign ula_x1 = xc[1];
    assign ula_x2 = xc[0];

    // Operand latch, per-pass captures and result/flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= OP_ADD;
            a_q        <= 8'h00;
            b_q        <= 8'h00;
            r_lo       <= 4'h0;
            r_hi       <= 4'h0;
            c          <= 1'b0;
            hc         <= 1'b0;
            lo_eq      <= 1'b0;
            lo_lt      <= 1'b0;
            result     <= 8'h00;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
        end else begin
            case (st)
                S_IDLE: begin
                    if (start) begin
                        op_q <= op_t'(op);
                        a_q  <= a;
                        b_q  <= b;
                    end
                end
                S_LO: begin
                    r_lo  <= ula_f0;
                    c     <= carry_now;
                    lo_eq <= ula_igual[0];
                    lo_lt <= ula_menor[0];
                end
                S_HI: begin
                    r_hi <= ula_f0;
                    hc   <= carry_now;
                    if (nxt == S_DONE) begin
                        case (op_q)
                            OP_SLT: begin
                                result     <= {7'b0, less};
                                flag_zero  <= ~less;
                                flag_carry <= 1'b0;
                            end
                            OP_BEQ: begin
                                result     <= {7'b0, equal};
                                flag_zero  <= ~equal;
                                flag_carry <= 1'b0;
                            end
                            default: begin
                                result     <= arith_res;
                                flag_zero  <= (arith_res == 8'h00);
                                flag_carry <= carry_now;
                            end
                        endcase
                    end
                end
                S_FIX: begin
                    r_hi       <= ula_f0;
                    result     <= arith_res;
                    flag_zero  <= (arith_res == 8'h00);
                    flag_carry <= hc | fix_c;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ula8_sequenciador.sv
// Directed bench: sequencer plus a behavioural 4-bit ULA, hand-computed results.
module tb_ula8_sequenciador;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] op = 2'b00;
    logic [7:0] a = 8'h00, b = 8'h00;
    logic       busy, done, flag_zero, flag_carry;
    logic [7:0] result;
    logic [3:0] ula_a, ula_b, ula_f0, ula_igual, ula_menor;
    logic       ula_x0, ula_x1, ula_x2;

    int checks = 0;
    int failures = 0;
    int lat;
    int ndone;

    always #5 clk = ~clk;

    ula8_sequenciador dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result),
        .flag_zero(flag_zero), .flag_carry(flag_carry),
        .ula_a(ula_a), .ula_b(ula_b),
        .ula_x0(ula_x0), .ula_x1(ula_x1), .ula_x2(ula_x2),
        .ula_f0(ula_f0), .ula_igual(ula_igual), .ula_menor(ula_menor)
    );

    // Behavioural 4-bit ULA: 000 add, 100 sub, compare outputs always valid
    always_comb begin
        case ({ula_x0, ula_x1, ula_x2})
            3'b000:  ula_f0 = ula_a + ula_b;
            3'b100:  ula_f0 = ula_a - ula_b;
            default: ula_f0 = 4'h0;
        endcase
        ula_igual = {3'b000, (ula_a == ula_b)};
        ula_menor = {3'b000, (ula_a < ula_b)};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [7:0] va,
                          input logic [7:0] vb, input logic [7:0] er, input logic ez,
                          input logic ec, input int elat);
        @(negedge clk);
        op = o; a = va; b = vb; start = 1'b1;
        @(posedge clk);
        lat = 1;
        #1 start = 1'b0;
        while (!done && lat < 10) begin
            @(posedge clk);
            lat++;
            #1;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_result"}, 32'(result), 32'(er));
        chk({tag, "_zero"}, 32'(flag_zero), 32'(ez));
        chk({tag, "_carry"}, 32'(flag_carry), 32'(ec));
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_busy_off"}, 32'(busy), 32'd0);
        chk({tag, "_hold"}, 32'(result), 32'(er));
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_flags", 32'({flag_zero, flag_carry}), 32'd0);
        chk("rst_ula", 32'({ula_a, ula_b, ula_x0, ula_x1, ula_x2}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add_27_15", 2'b00, 8'h27, 8'h15, 8'h3C, 1'b0, 1'b0, 3);
        run_op("add_0f_01", 2'b00, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0, 4);
        run_op("add_ff_01", 2'b00, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 4);
        run_op("add_f0_20", 2'b00, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b1, 3);
        run_op("sub_30_01", 2'b01, 8'h30, 8'h01, 8'h2F, 1'b0, 1'b0, 4);
        run_op("sub_00_01", 2'b01, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b1, 4);
        run_op("sub_55_55", 2'b01, 8'h55, 8'h55, 8'h00, 1'b1, 1'b0, 3);
        run_op("slt_17_21", 2'b10, 8'h17, 8'h21, 8'h01, 1'b0, 1'b0, 3);
        run_op("slt_21_17", 2'b10, 8'h21, 8'h17, 8'h00, 1'b1, 1'b0, 3);
        run_op("slt_25_23", 2'b10, 8'h25, 8'h23, 8'h00, 1'b1, 1'b0, 3);
        run_op("slt_23_25", 2'b10, 8'h23, 8'h25, 8'h01, 1'b0, 1'b0, 3);
        run_op("beq_77_77", 2'b11, 8'h77, 8'h77, 8'h01, 1'b0, 1'b0, 3);
        run_op("beq_77_76", 2'b11, 8'h77, 8'h76, 8'h00, 1'b1, 1'b0, 3);
        run_op("beq_67_77", 2'b11, 8'h67, 8'h77, 8'h00, 1'b1, 1'b0, 3);

        // start held high while busy; inputs change after accept
        @(negedge clk);
        op = 2'b00; a = 8'h27; b = 8'h15; start = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_lo_ula", 32'({ula_a, ula_b, ula_x0, ula_x1, ula_x2}), 32'({4'h7, 4'h5, 3'b000}));
        chk("hold_busy", 32'(busy), 32'd1);
        op = 2'b01; a = 8'hFF; b = 8'h01;
        lat = 1;
        ndone = 0;
        while (!done && lat < 10) begin
            @(posedge clk);
            lat++;
            #1;
        end
        chk("hold_lat", lat, 3);
        chk("hold_result", 32'(result), 32'h3C);
        @(negedge clk);
        start = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("hold_extra_done", ndone, 0);
        chk("hold_idle", 32'(busy), 32'd0);

        // Reset asserted while in HI
        @(negedge clk);
        op = 2'b00; a = 8'h0F; b = 8'h01; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_in_hi", 32'(ula_a), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_result", 32'(result), 32'd0);
        chk("mid_ula", 32'({ula_a, ula_b, ula_x0, ula_x1, ula_x2}), 32'd0);
        ndone = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("mid_no_done", ndone, 0);
        run_op("post_rst_add", 2'b00, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
